// File: rtl/adc_capture_controller_pkg.sv
// Shared definitions for the ADC capture controller.
//   cap_state_t : capture sequencer states
//   SAMPLE_W    : ADC sample width
//   FIFO_W      : transfer FIFO word width
//   PAD_W       : zero padding above the sample in each FIFO word
//   RAMP_MAX    : last ramp value before wrapping to zero
//   ramp_next() : next value of the test ramp
package adc_capture_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DRAIN,
        ST_OVERFLOW
    } cap_state_t;

    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned FIFO_W   = 16;
    localparam int unsigned PAD_W    = FIFO_W - SAMPLE_W;

    localparam logic [SAMPLE_W-1:0] RAMP_MAX = 10'd1023;

    function automatic logic [SAMPLE_W-1:0] ramp_next(input logic [SAMPLE_W-1:0] r);
        return (r == RAMP_MAX) ? '0 : r + SAMPLE_W'(1);
    endfunction

endpackage

// File: rtl/adc_capture_controller_sync_2ff.sv
// Generic two-flop synchroniser for a single host-domain control bit.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both flops
//   d_i   : asynchronous input
//   q_o   : synchronised output, two destination clocks of latency
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_capture_controller.sv
// Sequences ADC sample capture into the USB transfer FIFO in whole blocks.
//   clock          : ADC sample clock, all logic on the posedge
//   reset          : asynchronous active-high reset
//   collectEnable  : host capture request (asynchronous, synchronised here)
//   testMode       : 1 = write a 10-bit ramp instead of ADC samples
//   adcData        : ADC sample, valid every clock
//   fifoFull       : FIFO cannot take a write this cycle
//   fifoAlmostFull : FIFO above restart threshold; holds the ARM state
//   fifoWrite      : write strobe, aligned with fifoData
//   fifoData       : {zero pad, sample}, one cycle behind the source
//   blockEnd       : pulse on the last write of each block
//   captureActive  : high while capturing or draining
//   overflow       : sticky overflow flag, cleared on ARM entry
//   blockCount     : completed blocks since the last ARM
module adc_capture_controller
    import adc_capture_controller_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = 8192,
    parameter int unsigned BLOCK_CNT_W = 13
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                collectEnable,
    input  logic                testMode,
    input  logic [SAMPLE_W-1:0] adcData,
    input  logic                fifoFull,
    input  logic                fifoAlmostFull,
    output logic                fifoWrite,
    output logic [FIFO_W-1:0]   fifoData,
    output logic                blockEnd,
    output logic                captureActive,
    output logic                overflow,
    output logic [15:0]         blockCount
);

    localparam logic [BLOCK_CNT_W-1:0] LAST_WORD = BLOCK_CNT_W'(BLOCK_WORDS - 1);

    cap_state_t state_q, state_d;

    logic [BLOCK_CNT_W-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]    ramp_q, ramp_d;
    logic                   test_q, test_d;
    logic [15:0]            blk_cnt_q, blk_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   wr_q, wr_d;
    logic [FIFO_W-1:0]      data_q, data_d;
    logic                   end_q, end_d;
    logic                   act_q, act_d;

    logic collect_sync;
    logic last_word;

    sync_2ff u_collect_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (collectEnable),
        .q_o   (collect_sync)
    );

    assign last_word = (cnt_q == LAST_WORD);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ramp_d    = ramp_q;
        test_d    = test_q;
        blk_cnt_d = blk_cnt_q;
        ovf_d     = ovf_q;
        wr_d      = 1'b0;
        end_d     = 1'b0;
        // Registered alongside the data so it falls the cycle after the last write.
        act_d     = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
        data_d    = {{PAD_W{1'b0}}, (test_q ? ramp_q : adcData)};

        case (state_q)
            ST_IDLE: begin
                if (collect_sync) begin
                    state_d = ST_ARM;
                    ovf_d   = 1'b0;
                end
            end

            ST_ARM: begin
                cnt_d     = '0;
                blk_cnt_d = '0;
                ramp_d    = '0;
                test_d    = testMode;
                if (!collect_sync) begin
                    state_d = ST_IDLE;
                end else if (!fifoAlmostFull) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE, ST_DRAIN: begin
                // A full FIFO abandons the block, even on its final word.
                if (fifoFull) begin
                    state_d = ST_OVERFLOW;
                    ovf_d   = 1'b1;
                end else begin
                    wr_d   = 1'b1;
                    cnt_d  = cnt_q + BLOCK_CNT_W'(1);
                    ramp_d = ramp_next(ramp_q);
                    if (last_word) begin
                        end_d     = 1'b1;
                        blk_cnt_d = blk_cnt_q + 16'd1;
                    end
                    // Stopping only at a block boundary; DRAIN ignores a re-request.
                    if (last_word && ((state_q == ST_DRAIN) || !collect_sync)) begin
                        state_d = ST_IDLE;
                    end else if (!collect_sync) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_OVERFLOW: begin
                if (!collect_sync) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ramp_q    <= '0;
            test_q    <= 1'b0;
            blk_cnt_q <= '0;
            ovf_q     <= 1'b0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            end_q     <= 1'b0;
            act_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ramp_q    <= ramp_d;
            test_q    <= test_d;
            blk_cnt_q <= blk_cnt_d;
            ovf_q     <= ovf_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            end_q     <= end_d;
            act_q     <= act_d;
        end
    end

    assign fifoWrite     = wr_q;
    assign fifoData      = data_q;
    assign blockEnd      = end_q;
    assign captureActive = act_q;
    assign overflow      = ovf_q;
    assign blockCount    = blk_cnt_q;

endmodule

// File: doc/adc_capture_controller.md
Name: adc_capture_controller

Overview:
- Sequences RF sample capture between the ADC sampling stage and the USB transfer FIFO.
- Synchronises the host collect request, gates FIFO writes in whole blocks, and substitutes a ramp pattern in test mode.
- Detects FIFO overflow and latches it.
- Sits downstream of the ADC read register and upstream of the FX3/GPIF FIFO write port, all on the ADC sample clock.

Parameters:
BLOCK_WORDS, 8192, FIFO words per transfer block; power of two, minimum 4.
BLOCK_CNT_W, 13, width of the word counter; equals log2(BLOCK_WORDS).

Ports:
clock  input  1  ADC sample clock; all logic on the posedge.
reset  input  1  asynchronous, active-high reset.
collectEnable  input  1  host capture request; asynchronous to clock.
testMode  input  1  1 = replace ADC samples with the ramp pattern.
adcData  input  10  sample from the ADC read stage; valid every clock.
fifoFull  input  1  transfer FIFO cannot accept a write this cycle.
fifoAlmostFull  input  1  FIFO above its restart threshold.
fifoWrite  output  1  write strobe.
fifoData  output  16  {6'b0, sample}.
blockEnd  output  1  one-cycle pulse coincident with the last write of each block.
captureActive  output  1  high in CAPTURE or DRAIN.
overflow  output  1  sticky FIFO overflow flag.
blockCount  output  16  completed blocks since the last ARM; wraps 65535->0.

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops 0, ramp 0, word counter 0.
- collectEnable passes through a 2-flop synchroniser (collectSync); it adds 2 cycles of latency before any state decision.
- Data path:
  - Source is adcData, or the ramp when testLatched=1.
  - The source is registered once, so fifoData lags adcData by 1 cycle.
  - fifoWrite is registered in the same stage and is aligned with fifoData.
- Ramp: 10-bit counter that increments on every write and wraps 1023->0.
- IDLE:
  - No writes.
  - collectSync=1 -> ARM.
- ARM:
  - Clear the word counter, blockCount and ramp; latch testMode into testLatched.
  - Stay while fifoAlmostFull=1.
  - Leave when fifoAlmostFull=0, or when collectSync=0: go to CAPTURE (or IDLE if collectSync=0).
  - overflow is cleared on ARM entry.
- CAPTURE:
  - A write every cycle while fifoFull=0; word counter +1 per write.
  - On the write with counter==BLOCK_WORDS-1: blockEnd=1, counter wraps to 0, blockCount+1.
  - collectSync=0 -> DRAIN, unless that cycle's write is the last word of the block, in which case -> IDLE.
- DRAIN:
  - Writes continue until the last word of the current block (blockEnd pulses), then -> IDLE.
  - Only whole blocks ever reach the FIFO.
- fifoFull=1 in CAPTURE or DRAIN:
  - No write that cycle; go to OVERFLOW and set overflow=1.
  - fifoFull takes priority over collectSync falling and over block completion.
  - A partial block is abandoned and blockEnd is not pulsed.
- OVERFLOW:
  - No writes; overflow held.
  - collectSync=0 -> IDLE; overflow stays set until the next ARM.
- collectSync re-asserted during DRAIN: ignored; the block completes, then IDLE, and a new ARM follows on the next cycle if collectSync is still 1.
- testMode changes while capturing: ignored until the next ARM.
- Reset mid-capture: immediate return to reset values; no partial block flagged.

Decomposition:
- Shared package: state encoding (IDLE, ARM, CAPTURE, DRAIN, OVERFLOW), RAMP_MAX=10'd1023, fifoData pad width constant.
- Natural sub-module: sync_2ff (generic 2-flop bit synchroniser), reusable for other host-domain controls.

Test Plan (BLOCK_WORDS=8):
1. Assert collectEnable, testMode=0, adcData=10'h2A5, FIFO empty -> after sync+ARM latency, fifoWrite runs continuously with fifoData=16'h02A5; blockEnd on every 8th write; blockCount counts 1, 2, 3.
2. testMode=1, then collect -> fifoData = 0, 1, 2, ... from the first write; after 1024 writes it wraps to 0.
3. Drop collectEnable after the 3rd write of a block -> exactly 5 more writes, then blockEnd, then IDLE; captureActive falls the cycle after the last write.
4. Assert fifoFull on the 5th write of block 2 -> no write that cycle, no blockEnd, overflow=1, state OVERFLOW; overflow stays 1 after collect drops and clears on the next ARM.
5. fifoAlmostFull=1 during collect -> stays in ARM with no writes; release it -> first write 2 cycles later.
6. Assert reset mid-block -> fifoWrite, blockEnd, overflow and blockCount go to 0 asynchronously; no writes while reset is high.
